tx_fifo: RTL and testbench
==========================

TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of FIFO entries, a power of two and at least 2.
REQ-002 The block SHALL have parameter WIDTH, default 8: data width in bits.
REQ-003 The block SHALL have port pclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port psel, input, 1 bit: APB select.
REQ-006 The block SHALL have port pwrite, input, 1 bit: APB write strobe; a push request is psel=1 and pwrite=1.
REQ-007 The block SHALL have port pwdata, input, WIDTH bits: APB write data.
REQ-008 The block SHALL have port tx_ready, input, 1 bit: the transmit logic accepts the head byte this cycle.
REQ-009 The block SHALL have port txdata, output, WIDTH bits: head-of-FIFO byte to the transmit logic.
REQ-010 The block SHALL have port tx_valid, output, 1 bit: txdata holds a valid byte.
REQ-011 The block SHALL have port ssptxintr, output, 1 bit: FIFO full interrupt.
REQ-012 The block SHALL have port tx_empty, output, 1 bit: FIFO holds no entries.
REQ-013 The block SHALL have port count, output, clog2(DEPTH)+1 bits: current number of entries, 0..DEPTH.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag, a push was dropped while full.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH x WIDTH with read and write pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-016 A push SHALL be accepted on a rising edge when the push request is high and either count<DEPTH or a pop occurs on the same edge: pwdata goes to the write pointer, and the write pointer increments.
REQ-017 A pop SHALL occur on a rising edge when tx_valid=1 and tx_ready=1: the read pointer increments and the popped entry is zeroed.
REQ-018 count SHALL increment on push only, decrement on pop only, and stay unchanged on simultaneous push and pop, including at full.
REQ-019 When count=0, a simultaneous push request and tx_ready SHALL result in a push only, with no pop.
REQ-020 A push request when count=DEPTH with no pop on the same edge SHALL be dropped, leave storage and pointers unchanged, and set overrun to 1 on that edge.
REQ-021 overrun SHALL stay set until clear.
REQ-022 psel=1 with pwrite=0 SHALL have no effect on FIFO state.
REQ-023 txdata SHALL be first-word-fall-through: it equals storage[read pointer] when count>0 and 8'h00 (all zeros) when count=0.
REQ-024 txdata SHALL be valid in the cycle after the edge that pushed the byte into an empty FIFO, giving a latency of 1 cycle from push to tx_valid.
REQ-025 tx_valid SHALL equal (count!=0).
REQ-026 tx_empty SHALL equal (count==0).
REQ-027 ssptxintr SHALL equal (count==DEPTH), decoded from registered state with no extra cycle of delay.
REQ-028 Bytes SHALL leave in exactly the order they were accepted; dropped bytes SHALL never appear on txdata.
REQ-029 Pointer wrap from DEPTH-1 to 0 SHALL be seamless for both push and pop.

Reset
REQ-030 When clear=1 on a rising edge, the block SHALL zero both pointers, count, overrun and all storage entries, overriding any push or pop on that edge.
REQ-031 After reset the outputs SHALL be: txdata=0, tx_valid=0, tx_empty=1, ssptxintr=0, count=0, overrun=0.
REQ-032 Reset asserted mid-stream SHALL discard all queued bytes; the first push after reset SHALL appear at txdata with count=1.

Verification
REQ-033 Fill to full: hold tx_ready=0 and push 8'hA1, A2, A3, A4 -> count=4, ssptxintr=1 after the 4th edge, txdata=A1, overrun=0.
REQ-034 Overrun: while full, push 8'hFF with tx_ready=0 -> overrun=1 sticky, count=4, and draining yields A1..A4 with no FF.
REQ-035 Simultaneous at full: full with head A1, push 8'h55 with tx_ready=1 on one edge -> count stays 4, txdata=A2, and 55 exits fifth.
REQ-036 Empty edge case: count=0, push 8'h3C with tx_ready=1 -> count=1, txdata=3C, tx_valid=1 next cycle, no pop.
REQ-037 Wrap-around: stream 10 bytes 8'h01..8'h0A with alternating push/pop -> output order 01..0A, count never exceeds DEPTH.
REQ-038 Mid-operation reset: with count=3, assert clear for 1 cycle together with a push request -> all outputs at reset values; next push 8'h77 -> txdata=77, count=1.

Source files
------------

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - APB-fed transmit FIFO with first-word-fall-through head and sticky overrun.
// Circular buffer; a push into a full FIFO is accepted only when the head leaves on the same edge.
module tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     pclk,
   input  logic                     clear,
   input  logic                     psel,
   input  logic                     pwrite,
   input  logic [WIDTH-1:0]         pwdata,
   input  logic                     tx_ready,
   output logic [WIDTH-1:0]         txdata,
   output logic                     tx_valid,
   output logic                     ssptxintr,
   output logic                     tx_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overrun_q, overrun_d;

   logic push_req, full, pop, push;

   assign push_req = psel & pwrite;
   assign full     = (count_q == FULL_CNT);
   assign pop      = (count_q != '0) & tx_ready;
   assign push     = push_req & (~full | pop);

   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      if (pop)
         rd_ptr_d = rd_ptr_q + 1'b1;
      if (push)
         wr_ptr_d = wr_ptr_q + 1'b1;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
      if (push_req && !push)
         overrun_d = 1'b1;
   end

   always_ff @(posedge pclk) begin
      if (clear) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
         // At full with push+pop both pointers hit the same slot; the later write keeps the new byte.
         if (pop)
            mem_q[rd_ptr_q] <= '0;
         if (push)
            mem_q[wr_ptr_q] <= pwdata;
      end
   end

   assign txdata    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign tx_valid  = (count_q != '0);
   assign tx_empty  = (count_q == '0);
   assign ssptxintr = full;
   assign count     = count_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_tx_fifo.sv
// tb/tb_tx_fifo.sv - scoreboard bench for tx_fifo: directed scenarios plus random traffic.
module tb_tx_fifo;

   localparam int DEPTH = 4;
   localparam int WIDTH = 8;

   logic             pclk = 1'b0;
   logic             clear = 1'b1;
   logic             psel = 1'b0;
   logic             pwrite = 1'b0;
   logic [WIDTH-1:0] pwdata = '0;
   logic             tx_ready = 1'b0;
   logic [WIDTH-1:0] txdata;
   logic             tx_valid;
   logic             ssptxintr;
   logic             tx_empty;
   logic [2:0]       count;
   logic             overrun;

   int errors = 0;
   int checks = 0;

   logic [7:0] mq[$];   // reference FIFO contents, head at index 0
   logic [7:0] sb[$];   // bytes expected to leave, consumed by the monitor
   logic       mov;     // reference sticky overrun
   int         max_cnt;

   tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .pclk(pclk), .clear(clear), .psel(psel), .pwrite(pwrite), .pwdata(pwdata),
      .tx_ready(tx_ready), .txdata(txdata), .tx_valid(tx_valid), .ssptxintr(ssptxintr),
      .tx_empty(tx_empty), .count(count), .overrun(overrun)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a byte leaves on the next edge whenever valid and ready are both seen here.
   always @(negedge pclk) begin
      if (clear === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got %0h expected none", txdata);
         end else begin
            chk("pop_order", txdata, sb.pop_front());
         end
      end
   end

   task automatic step(input logic c, input logic s, input logic w, input logic [7:0] d, input logic r);
      bit pop_m, push_req_m;
      clear = c; psel = s; pwrite = w; pwdata = d; tx_ready = r;
      if (c) begin
         mq.delete();
         sb.delete();
         mov = 1'b0;
      end else begin
         push_req_m = s && w;
         pop_m = (mq.size() > 0) && r;
         if (push_req_m && (mq.size() < DEPTH || pop_m)) begin
            if (pop_m) void'(mq.pop_front());
            mq.push_back(d);
            sb.push_back(d);
         end else begin
            if (pop_m) void'(mq.pop_front());
            if (push_req_m) mov = 1'b1;
         end
      end
      @(posedge pclk);
      #1;
      if (mq.size() > max_cnt) max_cnt = mq.size();
      chk("count", count, mq.size());
      chk("tx_valid", tx_valid, mq.size() != 0);
      chk("tx_empty", tx_empty, mq.size() == 0);
      chk("ssptxintr", ssptxintr, mq.size() == DEPTH);
      chk("overrun", overrun, mov);
      chk("txdata", txdata, (mq.size() != 0) ? mq[0] : 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] fill[4];
      mov = 1'b0;
      max_cnt = 0;
      fill[0] = 8'hA1; fill[1] = 8'hA2; fill[2] = 8'hA3; fill[3] = 8'hA4;

      step(1, 0, 0, 8'h00, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", tx_empty, 1);
      chk("rst_txdata", txdata, 0);

      // Fill to full, then overrun, then simultaneous push/pop at full, then drain.
      for (int i = 0; i < 4; i++) step(0, 1, 1, fill[i], 0);
      chk("fill_count", count, 4);
      chk("fill_intr", ssptxintr, 1);
      chk("fill_head", txdata, 8'hA1);
      chk("fill_ovr", overrun, 0);
      step(0, 1, 1, 8'hFF, 0);
      chk("ovr_set", overrun, 1);
      chk("ovr_count", count, 4);
      step(0, 1, 0, 8'hEE, 0);
      chk("read_noeffect", count, 4);
      step(0, 1, 1, 8'h55, 1);
      chk("simul_count", count, 4);
      chk("simul_head", txdata, 8'hA2);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);
      chk("drain_empty", tx_empty, 1);
      chk("ovr_sticky", overrun, 1);

      // Push into empty with ready high: push only.
      step(1, 0, 0, 8'h00, 0);
      step(0, 1, 1, 8'h3C, 1);
      chk("empty_count", count, 1);
      chk("empty_head", txdata, 8'h3C);
      chk("empty_valid", tx_valid, 1);
      step(0, 0, 0, 8'h00, 1);

      // Alternating push/pop stream through the pointer wrap.
      max_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         step(0, 1, 1, 8'(i), 0);
         step(0, 0, 0, 8'h00, 1);
      end
      chk("wrap_max", max_cnt <= DEPTH, 1);
      chk("wrap_sb_empty", sb.size(), 0);

      // Mid-stream reset with a concurrent push request.
      for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h90 + 8'(i), 0);
      chk("mid_count", count, 3);
      step(1, 1, 1, 8'h99, 1);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_txdata", txdata, 0);
      chk("mid_rst_intr", ssptxintr, 0);
      step(0, 1, 1, 8'h77, 0);
      chk("post_rst_head", txdata, 8'h77);
      chk("post_rst_count", count, 1);

      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
              8'($urandom), $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 8'h00, 1);
      chk("final_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
